maze_game_fsm: RTL and testbench

Parametrised game-control engine for the VGA maze game. It sits between the button debouncer (single-cycle move/start pulses) and the renderer/map ROM. It runs the menu, the timed map preview and play phases, and performs wall-collision checks through a synchronous map ROM. It also handles a per-difficulty life budget and win/loss detection. Map size, start/goal cells, preview durations and life counts are all parameters.

---
 rtl/maze_game_fsm_if.sv | 45 ++++
 rtl/maze_game_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_maze_game_fsm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/maze_game_fsm_if.sv
// Bus between the maze game control engine and its surroundings
// (button debouncer, map ROM, renderer).
//   move_pulse  : one-cycle move pulses [0] up, [1] down, [2] left, [3] right
//   start_pulse : one-cycle start/acknowledge pulse
//   map_addr    : registered ROM row address
//   map_row     : ROM row data, valid one cycle after map_addr
//   game_state  : 0 MENU, 1 SHOW, 2 PLAY, 3 FETCH, 4 CHECK, 5 LOST, 6 WON
//   difficulty  : 0 easy, 1 medium, 2 hard
//   player_x/y  : current player cell
//   lives_left  : remaining wall hits
//   map_visible : renderer draws walls when 1
//   lost/won    : level flags
// master = environment side, slave = game engine side.
interface maze_game_fsm_if #(
    parameter int MAP_W = 30,
    parameter int MAP_H = 21
);
    localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;

    logic [3:0]       move_pulse;
    logic             start_pulse;
    logic [YW-1:0]    map_addr;
    logic [MAP_W-1:0] map_row;
    logic [2:0]       game_state;
    logic [1:0]       difficulty;
    logic [XW-1:0]    player_x;
    logic [YW-1:0]    player_y;
    logic [2:0]       lives_left;
    logic             map_visible;
    logic             lost;
    logic             won;

    modport master (
        output move_pulse, start_pulse, map_row,
        input  map_addr, game_state, difficulty, player_x, player_y,
               lives_left, map_visible, lost, won
    );

    modport slave (
        input  move_pulse, start_pulse, map_row,
        output map_addr, game_state, difficulty, player_x, player_y,
               lives_left, map_visible, lost, won
    );
endinterface

// File: rtl/maze_game_fsm.sv
// Maze game control engine: menu with difficulty selection, timed map
// preview, play phase with wall-collision checks through a synchronous
// map ROM, life budget and win/loss detection.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : maze_game_fsm_if.slave (move/start pulses, ROM address/data,
//           game state, difficulty, player position, lives, flags)
module maze_game_fsm #(
    parameter int MAP_W      = 30,
    parameter int MAP_H      = 21,
    parameter int START_X    = 0,
    parameter int START_Y    = 20,
    parameter int GOAL_X     = 29,
    parameter int GOAL_Y     = 0,
    parameter int SHOW_EASY  = 100000000,
    parameter int SHOW_MED   = 50000000,
    parameter int SHOW_HARD  = 25000000,
    parameter int LIVES_EASY = 3,
    parameter int LIVES_MED  = 2,
    parameter int LIVES_HARD = 1
) (
    input logic            clk,
    input logic            reset,
    maze_game_fsm_if.slave bus
);
    localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int SHOW_MAX = (SHOW_EASY > SHOW_MED)
                            ? ((SHOW_EASY > SHOW_HARD) ? SHOW_EASY : SHOW_HARD)
                            : ((SHOW_MED  > SHOW_HARD) ? SHOW_MED  : SHOW_HARD);
    localparam int CW = $clog2(SHOW_MAX) + 1;

    localparam logic [XW-1:0] SX = XW'(START_X);
    localparam logic [YW-1:0] SY = YW'(START_Y);
    localparam logic [XW-1:0] GX = XW'(GOAL_X);
    localparam logic [YW-1:0] GY = YW'(GOAL_Y);

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_SHOW  = 3'd1,
        S_PLAY  = 3'd2,
        S_FETCH = 3'd3,
        S_CHECK = 3'd4,
        S_LOST  = 3'd5,
        S_WON   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    diff_q, diff_d;
    logic [XW-1:0] px_q, px_d, tx_q, tx_d;
    logic [YW-1:0] py_q, py_d, ty_q, ty_d;
    logic [YW-1:0] addr_q, addr_d;
    logic [2:0]    lives_q, lives_d;
    logic          vis_q, vis_d;
    logic          lost_q, lost_d;
    logic          won_q, won_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Target cell one bit wider than the coordinate: stepping below 0 wraps
    // to all-ones, so a single unsigned "< size" compare catches both edges.
    logic [XW:0]   tx_w;
    logic [YW:0]   ty_w;
    logic          in_range;
    logic          move_any;
    logic [CW-1:0] show_last;
    logic [2:0]    lives_init;

    always_comb begin
        tx_w = {1'b0, px_q};
        ty_w = {1'b0, py_q};
        if (bus.move_pulse[0])      ty_w = {1'b0, py_q} - (YW+1)'(1);
        else if (bus.move_pulse[1]) ty_w = {1'b0, py_q} + (YW+1)'(1);
        else if (bus.move_pulse[2]) tx_w = {1'b0, px_q} - (XW+1)'(1);
        else if (bus.move_pulse[3]) tx_w = {1'b0, px_q} + (XW+1)'(1);
        in_range = (tx_w < (XW+1)'(MAP_W)) && (ty_w < (YW+1)'(MAP_H));
        move_any = |bus.move_pulse;
    end

    always_comb begin
        case (diff_q)
            2'd0:    begin show_last = CW'(SHOW_EASY - 1); lives_init = 3'(LIVES_EASY); end
            2'd1:    begin show_last = CW'(SHOW_MED - 1);  lives_init = 3'(LIVES_MED);  end
            default: begin show_last = CW'(SHOW_HARD - 1); lives_init = 3'(LIVES_HARD); end
        endcase
    end

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        px_d    = px_q;
        py_d    = py_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        addr_d  = addr_q;
        lives_d = lives_q;
        vis_d   = vis_q;
        lost_d  = lost_q;
        won_d   = won_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_MENU: begin
                if (bus.start_pulse) begin
                    state_d = S_SHOW;
                    vis_d   = 1'b1;
                    lives_d = lives_init;
                    px_d    = SX;
                    py_d    = SY;
                    cnt_d   = '0;
                end else if (bus.move_pulse[0]) begin
                    diff_d = (diff_q == 2'd0) ? 2'd2 : diff_q - 2'd1;
                end else if (bus.move_pulse[1]) begin
                    diff_d = (diff_q == 2'd2) ? 2'd0 : diff_q + 2'd1;
                end
            end
            S_SHOW: begin
                if (cnt_q == show_last) begin
                    state_d = S_PLAY;
                    vis_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PLAY: begin
                if (move_any && in_range) begin
                    tx_d    = tx_w[XW-1:0];
                    ty_d    = ty_w[YW-1:0];
                    addr_d  = ty_w[YW-1:0];
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.map_row[tx_q]) begin
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = S_LOST;
                        lost_d  = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    px_d = tx_q;
                    py_d = ty_q;
                    if (tx_q == GX && ty_q == GY) begin
                        state_d = S_WON;
                        won_d   = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_LOST, S_WON: begin
                if (bus.start_pulse) begin
                    state_d = S_MENU;
                    lost_d  = 1'b0;
                    won_d   = 1'b0;
                    px_d    = SX;
                    py_d    = SY;
                    lives_d = '0;
                end
            end
            default: state_d = S_MENU;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_MENU;
            diff_q  <= '0;
            px_q    <= SX;
            py_q    <= SY;
            tx_q    <= SX;
            ty_q    <= SY;
            addr_q  <= SY;
            lives_q <= '0;
            vis_q   <= 1'b0;
            lost_q  <= 1'b0;
            won_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            addr_q  <= addr_d;
            lives_q <= lives_d;
            vis_q   <= vis_d;
            lost_q  <= lost_d;
            won_q   <= won_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.game_state  = state_q;
    assign bus.difficulty  = diff_q;
    assign bus.player_x    = px_q;
    assign bus.player_y    = py_q;
    assign bus.map_addr    = addr_q;
    assign bus.lives_left  = lives_q;
    assign bus.map_visible = vis_q;
    assign bus.lost        = lost_q;
    assign bus.won         = won_q;
endmodule

// File: tb/tb_maze_game_fsm.sv
// Directed bench for maze_game_fsm: 30x21 map, walls at (1,20) and (0,19)
// (switchable off for the free-path run), short preview lengths.
module tb_maze_game_fsm;
    logic clk;
    logic reset;
    logic walls_en;
    int   checks;
    int   failures;

    maze_game_fsm_if #(.MAP_W(30), .MAP_H(21)) bus ();

    maze_game_fsm #(
        .MAP_W(30), .MAP_H(21),
        .START_X(0), .START_Y(20), .GOAL_X(29), .GOAL_Y(0),
        .SHOW_EASY(4), .SHOW_MED(3), .SHOW_HARD(2),
        .LIVES_EASY(3), .LIVES_MED(2), .LIVES_HARD(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] rom_row(input logic [4:0] y, input logic en);
        logic [29:0] r;
        r = '0;
        if (en && y == 5'd20) r[1] = 1'b1;
        if (en && y == 5'd19) r[0] = 1'b1;
        return r;
    endfunction

    // Synchronous ROM: one cycle of latency from map_addr.
    always_ff @(posedge clk) bus.map_row <= rom_row(bus.map_addr, walls_en);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
    endtask

    task automatic do_move(input logic [3:0] m);
        bus.move_pulse = m;
        tick();
        bus.move_pulse = 4'b0000;
        tick();
        tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(bus.game_state), 0);
        check({tag, "_diff"},  32'(bus.difficulty), 0);
        check({tag, "_px"},    32'(bus.player_x), 0);
        check({tag, "_py"},    32'(bus.player_y), 20);
        check({tag, "_addr"},  32'(bus.map_addr), 20);
        check({tag, "_lives"}, 32'(bus.lives_left), 0);
        check({tag, "_vis"},   32'(bus.map_visible), 0);
        check({tag, "_lost"},  32'(bus.lost), 0);
        check({tag, "_won"},   32'(bus.won), 0);
    endtask

    // Asserted between edges; outputs must clear before the next clock.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #2;
        check_reset(tag);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        walls_en = 1'b1;
        bus.move_pulse = 4'b0000;
        bus.start_pulse = 1'b0;
        repeat (2) tick();
        check_reset("rst");
        reset = 1'b0;
        tick();

        // Easy start: 4-cycle preview.
        start_game();
        check("s1_state", 32'(bus.game_state), 1);
        check("s1_vis", 32'(bus.map_visible), 1);
        check("s1_lives", 32'(bus.lives_left), 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s1_show_hold", 32'(bus.game_state), 1);
            check("s1_vis_hold", 32'(bus.map_visible), 1);
        end
        tick();
        check("s1_play", 32'(bus.game_state), 2);
        check("s1_vis_off", 32'(bus.map_visible), 0);
        check("s1_px", 32'(bus.player_x), 0);
        check("s1_py", 32'(bus.player_y), 20);

        // Edge moves dropped.
        bus.move_pulse = 4'b0100;
        tick();
        bus.move_pulse = 4'b0000;
        check("s2_left_state", 32'(bus.game_state), 2);
        bus.move_pulse = 4'b0010;
        tick();
        bus.move_pulse = 4'b0000;
        check("s2_down_state", 32'(bus.game_state), 2);
        check("s2_px", 32'(bus.player_x), 0);
        check("s2_py", 32'(bus.player_y), 20);
        check("s2_lives", 32'(bus.lives_left), 3);

        // Right into wall (1,20).
        bus.move_pulse = 4'b1000;
        tick();
        bus.move_pulse = 4'b0000;
        check("s3_fetch", 32'(bus.game_state), 3);
        check("s3_addr", 32'(bus.map_addr), 20);
        tick();
        check("s3_check", 32'(bus.game_state), 4);
        tick();
        check("s3_play", 32'(bus.game_state), 2);
        check("s3_px", 32'(bus.player_x), 0);
        check("s3_py", 32'(bus.player_y), 20);
        check("s3_lives", 32'(bus.lives_left), 2);

        // Back to menu, difficulty selection with wrap.
        async_reset("rst_play");
        tick();
        bus.move_pulse = 4'b0001;
        tick();
        check("s4_up_wrap", 32'(bus.difficulty), 2);
        bus.move_pulse = 4'b0010;
        tick();
        check("s4_down_wrap", 32'(bus.difficulty), 0);
        bus.move_pulse = 4'b0001;
        tick();
        bus.move_pulse = 4'b0000;
        check("s4_hard", 32'(bus.difficulty), 2);
        // Start together with a move: start wins.
        bus.move_pulse = 4'b0010;
        bus.start_pulse = 1'b1;
        tick();
        bus.move_pulse = 4'b0000;
        bus.start_pulse = 1'b0;
        check("s4_start_wins", 32'(bus.game_state), 1);
        check("s4_diff_kept", 32'(bus.difficulty), 2);
        check("s4_lives", 32'(bus.lives_left), 1);
        tick();
        check("s4_show_hold", 32'(bus.game_state), 1);
        tick();
        check("s4_play", 32'(bus.game_state), 2);
        do_move(4'b0001);
        check("s4_lost_state", 32'(bus.game_state), 5);
        check("s4_lost", 32'(bus.lost), 1);
        check("s4_lives0", 32'(bus.lives_left), 0);
        check("s4_py", 32'(bus.player_y), 20);
        start_game();
        check("s4_menu", 32'(bus.game_state), 0);
        check("s4_lost_clr", 32'(bus.lost), 0);
        check("s4_diff", 32'(bus.difficulty), 2);

        // Free path to the goal.
        walls_en = 1'b0;
        start_game();
        tick();
        tick();
        check("s5_play", 32'(bus.game_state), 2);
        bus.move_pulse = 4'b0001;
        tick();
        check("s5_fetch", 32'(bus.game_state), 3);
        tick();
        bus.move_pulse = 4'b0000;
        tick();
        check("s5_single_step", 32'(bus.player_y), 19);
        check("s5_back_play", 32'(bus.game_state), 2);
        for (int i = 0; i < 19; i++) do_move(4'b0001);
        check("s5_top_py", 32'(bus.player_y), 0);
        bus.move_pulse = 4'b0001;
        tick();
        bus.move_pulse = 4'b0000;
        check("s5_top_drop", 32'(bus.game_state), 2);
        for (int i = 0; i < 28; i++) do_move(4'b1000);
        check("s5_px28", 32'(bus.player_x), 28);
        check("s5_not_won", 32'(bus.won), 0);
        do_move(4'b1000);
        check("s5_won_state", 32'(bus.game_state), 6);
        check("s5_won", 32'(bus.won), 1);
        check("s5_px", 32'(bus.player_x), 29);
        check("s5_py", 32'(bus.player_y), 0);
        start_game();
        check("s5_menu", 32'(bus.game_state), 0);
        check("s5_won_clr", 32'(bus.won), 0);

        // Reset during SHOW, then during CHECK.
        walls_en = 1'b1;
        start_game();
        check("s6_show", 32'(bus.game_state), 1);
        async_reset("rst_show");
        tick();
        start_game();
        check("s6_vis", 32'(bus.map_visible), 1);
        check("s6_lives", 32'(bus.lives_left), 3);
        repeat (4) tick();
        check("s6_play", 32'(bus.game_state), 2);
        bus.move_pulse = 4'b1000;
        tick();
        bus.move_pulse = 4'b0000;
        tick();
        check("s6_check", 32'(bus.game_state), 4);
        async_reset("rst_check");
        tick();
        start_game();
        check("s6_restart", 32'(bus.game_state), 1);
        check("s6_restart_vis", 32'(bus.map_visible), 1);
        check("s6_restart_lives", 32'(bus.lives_left), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
